// File: rtl/rc4_key_search.sv
// Brute-force RC4 key-search controller.
// Walks candidate keys from KEY_START to KEY_MAX. For each key it launches the RC4 engine and
// waits for it to finish. It then scans the decrypted message in d_memory and stops on the first
// message made only of lowercase letters and spaces.
// Optional build macro: KEY_SEARCH_UPPER_EN. When defined, uppercase letters also count as
// plaintext.
module rc4_key_search #(
  parameter int unsigned MSG_LEN   = 32,
  parameter logic [23:0] KEY_START = 24'h000000,
  parameter logic [23:0] KEY_MAX   = 24'h3FFFFF
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       start,
  input  logic                       rc4_done,
  input  logic [7:0]                 dram_q,
  output logic                       rc4_start,
  output logic [23:0]                secret_key,
  output logic [$clog2(MSG_LEN)-1:0] dram_addr,
  output logic                       dram_rd_sel,
  output logic                       busy,
  output logic                       key_found,
  output logic                       key_exhausted
);

  localparam int unsigned AddrW = $clog2(MSG_LEN);
  localparam logic [AddrW-1:0] LastAddr = AddrW'(MSG_LEN - 1);

  typedef enum logic [2:0] {
    StIdle,
    StLaunch,
    StWaitRc4,
    StScan,
    StNextKey,
    StFound,
    StExhausted
  } state_e;

  state_e           state_q, state_d;
  logic [23:0]      key_q, key_d;
  logic [AddrW-1:0] addr_q, addr_d;
  // chk_vld_q: dram_q holds a byte fetched during the previous SCAN cycle.
  // chk_last_q: that byte was fetched from the final message address.
  logic             chk_vld_q, chk_last_q;
  logic             byte_ok;

  // Plaintext classification of the byte returned by d_memory this cycle.
  always_comb begin
    byte_ok = ((dram_q >= 8'h61) && (dram_q <= 8'h7A)) || (dram_q == 8'h20);
`ifdef KEY_SEARCH_UPPER_EN
    byte_ok = byte_ok || ((dram_q >= 8'h41) && (dram_q <= 8'h5A));
`else
    byte_ok = byte_ok;
`endif
  end

  // Next-state, datapath updates and state-decoded outputs.
  always_comb begin
    state_d       = state_q;
    key_d         = key_q;
    addr_d        = addr_q;
    rc4_start     = 1'b0;
    dram_rd_sel   = 1'b0;
    busy          = 1'b1;
    key_found     = 1'b0;
    key_exhausted = 1'b0;
    unique case (state_q)
      StIdle: begin
        busy = 1'b0;
        if (start) begin
          key_d   = KEY_START;
          state_d = StLaunch;
        end
      end
      StLaunch: begin
        rc4_start = 1'b1;
        state_d   = StWaitRc4;
      end
      StWaitRc4: begin
        addr_d = '0;
        if (rc4_done) begin
          state_d = StScan;
        end
      end
      StScan: begin
        dram_rd_sel = 1'b1;
        // Saturate so the final address stays presented until its byte is checked.
        if (addr_q != LastAddr) begin
          addr_d = addr_q + 1'b1;
        end
        if (chk_vld_q) begin
          if (!byte_ok) begin
            state_d = StNextKey;
          end else if (chk_last_q) begin
            state_d = StFound;
          end
        end
      end
      StNextKey: begin
        if (key_q == KEY_MAX) begin
          state_d = StExhausted;
        end else begin
          key_d   = key_q + 24'd1;
          state_d = StLaunch;
        end
      end
      StFound: begin
        busy      = 1'b0;
        key_found = 1'b1;
        if (start) begin
          key_d   = KEY_START;
          state_d = StLaunch;
        end
      end
      StExhausted: begin
        busy          = 1'b0;
        key_exhausted = 1'b1;
        if (start) begin
          key_d   = KEY_START;
          state_d = StLaunch;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= StIdle;
      key_q      <= KEY_START;
      addr_q     <= '0;
      chk_vld_q  <= 1'b0;
      chk_last_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      key_q      <= key_d;
      addr_q     <= addr_d;
      chk_vld_q  <= (state_q == StScan);
      chk_last_q <= (state_q == StScan) && (addr_q == LastAddr);
    end
  end

  assign secret_key = key_q;
  assign dram_addr  = addr_q;

endmodule

// File: tb/tb_rc4_key_search.sv
// Self-checking bench for rc4_key_search.
// Models the RC4 engine (done 10 cycles after each launch) and a key-dependent d_memory.
// A reference model predicts which key passes, where each failing scan stops, and the cycle
// timing.
module tb_rc4_key_search;

  localparam int          MSG_LEN = 32;
  localparam int          RC4_LAT = 10;
  localparam int          BUDGET  = 2000;
  localparam logic [23:0] EX_KEY  = 24'h00000F;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        start_ex = 1'b0;
  logic        spur_done = 1'b0;
  logic        model_done = 1'b0;
  logic        model_done_ex = 1'b0;
  logic        rc4_done, rc4_done_ex;
  logic [7:0]  dram_q = 8'h00;
  logic [7:0]  dram_q_ex = 8'h00;

  logic        rc4_start, dram_rd_sel, busy, key_found, key_exhausted;
  logic [23:0] secret_key;
  logic [4:0]  dram_addr;
  logic        rc4_start_ex, dram_rd_sel_ex, busy_ex, key_found_ex, key_exhausted_ex;
  logic [23:0] secret_key_ex;
  logic [4:0]  dram_addr_ex;

  int checks = 0;
  int errors = 0;
  int cnt = 0;
  int cnt_ex = 0;

  logic [7:0] mem_tab [8][MSG_LEN];
  logic [7:0] mem_ex [MSG_LEN];
  logic [7:0] bad_tab [8];

  always #5 clk = ~clk;

  assign rc4_done    = model_done | spur_done;
  assign rc4_done_ex = model_done_ex;

  rc4_key_search #(
    .MSG_LEN  (MSG_LEN),
    .KEY_START(24'h000000),
    .KEY_MAX  (24'h3FFFFF)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .rc4_done     (rc4_done),
    .dram_q       (dram_q),
    .rc4_start    (rc4_start),
    .secret_key   (secret_key),
    .dram_addr    (dram_addr),
    .dram_rd_sel  (dram_rd_sel),
    .busy         (busy),
    .key_found    (key_found),
    .key_exhausted(key_exhausted)
  );

  rc4_key_search #(
    .MSG_LEN  (MSG_LEN),
    .KEY_START(EX_KEY),
    .KEY_MAX  (EX_KEY)
  ) dut_ex (
    .clk          (clk),
    .reset        (reset),
    .start        (start_ex),
    .rc4_done     (rc4_done_ex),
    .dram_q       (dram_q_ex),
    .rc4_start    (rc4_start_ex),
    .secret_key   (secret_key_ex),
    .dram_addr    (dram_addr_ex),
    .dram_rd_sel  (dram_rd_sel_ex),
    .busy         (busy_ex),
    .key_found    (key_found_ex),
    .key_exhausted(key_exhausted_ex)
  );

  // d_memory: synchronous read, decrypted contents depend on the key in use.
  always @(posedge clk) dram_q <= mem_tab[secret_key[2:0]][dram_addr];
  always @(posedge clk) dram_q_ex <= mem_ex[dram_addr_ex];

  // RC4 engine: done pulse RC4_LAT cycles after each launch.
  always @(negedge clk) begin
    model_done = 1'b0;
    if (cnt != 0) begin
      cnt = cnt - 1;
      if (cnt == 0) model_done = 1'b1;
    end
    if (rc4_start === 1'b1) cnt = RC4_LAT;
  end

  always @(negedge clk) begin
    model_done_ex = 1'b0;
    if (cnt_ex != 0) begin
      cnt_ex = cnt_ex - 1;
      if (cnt_ex == 0) model_done_ex = 1'b1;
    end
    if (rc4_start_ex === 1'b1) cnt_ex = RC4_LAT;
  end

  // Reference: plaintext rule and first failing index of a key's message (-1 = passes).
  function automatic bit ref_ok(input logic [7:0] b);
    bit ok;
    ok = (b == 8'h20) || (b >= 8'h61 && b <= 8'h7A);
`ifdef KEY_SEARCH_UPPER_EN
    ok = ok || (b >= 8'h41 && b <= 8'h5A);
`endif
    return ok;
  endfunction

  function automatic int first_bad(input int k);
    int r;
    r = -1;
    for (int i = MSG_LEN - 1; i >= 0; i--) begin
      if (!ref_ok(mem_tab[k % 8][i])) r = i;
    end
    return r;
  endfunction

  task automatic fill_attack();
    string s;
    s = "attack at dawn";
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        mem_tab[k][i] = (i < s.len()) ? s[i] : 8'h20;
      end
    end
  endtask

  task automatic fill_random(input int edge_pos);
    int pass_k, p, r;
    pass_k = $urandom_range(0, 7);
    for (int k = 0; k < 8; k++) begin
      for (int i = 0; i < MSG_LEN; i++) begin
        r = $urandom_range(0, 26);
        mem_tab[k][i] = (r == 26) ? 8'h20 : 8'(8'h61 + r);
      end
      if (k != pass_k) begin
        p = (edge_pos >= 0 && k == 0) ? edge_pos : $urandom_range(0, MSG_LEN - 1);
        mem_tab[k][p] = bad_tab[$urandom_range(0, 7)];
      end
    end
  endtask

  // One full search on the main DUT, checked against the reference model at every launch.
  task automatic run_search(input string name, input bit inject);
    int exp_key, launches, launch_cyc, max_addr, prev_key, a, cyc, end_cyc, exp_max;
    bit done;
    exp_key = -1;
    for (int k = 0; k < 8; k++) begin
      if (exp_key < 0 && first_bad(k) < 0) exp_key = k;
    end
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    if (inject) spur_done = 1'b1;
    checks++;
    if (rc4_start !== 1'b1 || busy !== 1'b1 || key_found !== 1'b0 || key_exhausted !== 1'b0 ||
        secret_key !== 24'h0) begin
      errors++;
      $display("FAIL %s launch: got start=%b busy=%b found=%b exh=%b key=%h expected 1 1 0 0 0",
               name, rc4_start, busy, key_found, key_exhausted, secret_key);
    end
    launches = 1; launch_cyc = 0; max_addr = 0; prev_key = 0; done = 0; cyc = 1; end_cyc = 0;
    while (cyc < BUDGET && !done) begin
      @(negedge clk);
      spur_done = 1'b0;
      start = 1'b0;
      if (inject && (cyc == 2 || cyc == RC4_LAT + 6)) start = 1'b1;
      if (inject && cyc == RC4_LAT + 6) spur_done = 1'b1;
      if (dram_rd_sel === 1'b1 && int'(dram_addr) > max_addr) max_addr = int'(dram_addr);
      if (rc4_start === 1'b1) begin
        a = first_bad(prev_key);
        exp_max = (a + 1 > MSG_LEN - 1) ? MSG_LEN - 1 : a + 1;
        checks++;
        if (cyc - launch_cyc != RC4_LAT + a + 4) begin
          errors++;
          $display("FAIL %s relaunch_gap key %0d: got %0d expected %0d", name, prev_key,
                   cyc - launch_cyc, RC4_LAT + a + 4);
        end
        checks++;
        if (max_addr != exp_max) begin
          errors++;
          $display("FAIL %s scan_depth key %0d: got %0d expected %0d", name, prev_key,
                   max_addr, exp_max);
        end
        checks++;
        if (secret_key !== 24'(prev_key + 1)) begin
          errors++;
          $display("FAIL %s next_key: got %h expected %h", name, secret_key,
                   24'(prev_key + 1));
        end
        prev_key++;
        launches++;
        launch_cyc = cyc;
        max_addr = 0;
      end
      if (key_found === 1'b1 || key_exhausted === 1'b1) begin
        done = 1;
        end_cyc = cyc;
      end
      cyc++;
    end
    start = 1'b0;
    spur_done = 1'b0;
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: got no result after %0d cycles, expected key_found", name,
               BUDGET);
    end
    checks++;
    if (key_found !== 1'b1 || key_exhausted !== 1'b0 || busy !== 1'b0 || dram_rd_sel !== 1'b0) begin
      errors++;
      $display("FAIL %s final_flags: got found=%b exh=%b busy=%b sel=%b expected 1 0 0 0", name,
               key_found, key_exhausted, busy, dram_rd_sel);
    end
    checks++;
    if (secret_key !== 24'(exp_key)) begin
      errors++;
      $display("FAIL %s found_key: got %h expected %h", name, secret_key, 24'(exp_key));
    end
    checks++;
    if (launches != exp_key + 1) begin
      errors++;
      $display("FAIL %s launches: got %0d expected %0d", name, launches, exp_key + 1);
    end
    checks++;
    if (end_cyc - launch_cyc != RC4_LAT + MSG_LEN + 2) begin
      errors++;
      $display("FAIL %s found_latency: got %0d expected %0d", name, end_cyc - launch_cyc,
               RC4_LAT + MSG_LEN + 2);
    end
    checks++;
    if (max_addr != MSG_LEN - 1) begin
      errors++;
      $display("FAIL %s full_scan_depth: got %0d expected %0d", name, max_addr, MSG_LEN - 1);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (rc4_start !== 1'b0 || dram_rd_sel !== 1'b0 || busy !== 1'b0 || key_found !== 1'b0 ||
        key_exhausted !== 1'b0 || secret_key !== 24'h0 || dram_addr !== 5'd0) begin
      errors++;
      $display("FAIL reset_outputs: got st=%b sel=%b busy=%b f=%b e=%b key=%h addr=%0d expected 0",
               rc4_start, dram_rd_sel, busy, key_found, key_exhausted, secret_key, dram_addr);
    end
    checks++;
    if (secret_key_ex !== EX_KEY || busy_ex !== 1'b0) begin
      errors++;
      $display("FAIL reset_ex_key: got %h busy=%b expected %h 0", secret_key_ex, busy_ex, EX_KEY);
    end
    reset = 1'b0;
  endtask

  task automatic test_attack();
    fill_attack();
    run_search("attack", 1'b0);
  endtask

  task automatic test_step();
    fill_attack();
    for (int k = 0; k < 3; k++) mem_tab[k][5] = 8'h41;
    run_search("step", 1'b0);
  endtask

  task automatic test_spurious();
    fill_attack();
    run_search("spurious", 1'b1);
  endtask

  task automatic test_random();
    fill_random(MSG_LEN - 1);
    run_search("rand_last", 1'b0);
    fill_random(0);
    run_search("rand_first", 1'b0);
    for (int r = 0; r < 3; r++) begin
      fill_random(-1);
      run_search("rand", 1'b0);
    end
  endtask

  task automatic test_exhaust();
    int cyc, end_cyc, launches;
    bit done;
    for (int i = 0; i < MSG_LEN; i++) mem_ex[i] = 8'h61;
    mem_ex[0] = 8'h00;
    @(negedge clk);
    start_ex = 1'b1;
    @(negedge clk);
    start_ex = 1'b0;
    checks++;
    if (rc4_start_ex !== 1'b1 || secret_key_ex !== EX_KEY) begin
      errors++;
      $display("FAIL exhaust_launch: got start=%b key=%h expected 1 %h", rc4_start_ex,
               secret_key_ex, EX_KEY);
    end
    launches = 1; done = 0; cyc = 1; end_cyc = 0;
    while (cyc < BUDGET && !done) begin
      @(negedge clk);
      if (rc4_start_ex === 1'b1) launches++;
      if (key_found_ex === 1'b1 || key_exhausted_ex === 1'b1) begin
        done = 1;
        end_cyc = cyc;
      end
      cyc++;
    end
    checks++;
    if (key_exhausted_ex !== 1'b1 || key_found_ex !== 1'b0 || busy_ex !== 1'b0) begin
      errors++;
      $display("FAIL exhaust_flags: got exh=%b found=%b busy=%b expected 1 0 0",
               key_exhausted_ex, key_found_ex, busy_ex);
    end
    checks++;
    if (secret_key_ex !== EX_KEY || launches != 1) begin
      errors++;
      $display("FAIL exhaust_key: got key=%h launches=%0d expected %h 1", secret_key_ex,
               launches, EX_KEY);
    end
    checks++;
    if (end_cyc != RC4_LAT + 4) begin
      errors++;
      $display("FAIL exhaust_latency: got %0d expected %0d", end_cyc, RC4_LAT + 4);
    end
  endtask

  task automatic test_reset_mid();
    int cyc;
    bit hit;
    fill_attack();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    hit = 0; cyc = 0;
    while (cyc < BUDGET && !hit) begin
      @(negedge clk);
      if (dram_rd_sel === 1'b1 && dram_addr === 5'd12) hit = 1;
      cyc++;
    end
    checks++;
    if (!hit) begin
      errors++;
      $display("FAIL midscan_reach: got no address 12 within %0d cycles, expected it", BUDGET);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (rc4_start !== 1'b0 || dram_rd_sel !== 1'b0 || busy !== 1'b0 || key_found !== 1'b0 ||
        key_exhausted !== 1'b0 || secret_key !== 24'h0 || dram_addr !== 5'd0) begin
      errors++;
      $display("FAIL midscan_reset: got st=%b sel=%b busy=%b f=%b e=%b key=%h addr=%0d expected 0",
               rc4_start, dram_rd_sel, busy, key_found, key_exhausted, secret_key, dram_addr);
    end
    reset = 1'b0;
    run_search("after_reset", 1'b0);
  endtask

  initial begin
    bad_tab[0] = 8'h00; bad_tab[1] = 8'h41; bad_tab[2] = 8'h5A; bad_tab[3] = 8'h60;
    bad_tab[4] = 8'h7B; bad_tab[5] = 8'h1F; bad_tab[6] = 8'h21; bad_tab[7] = 8'hFF;
    fill_attack();
    for (int i = 0; i < MSG_LEN; i++) mem_ex[i] = 8'h61;
    test_reset();
    test_attack();
    test_step();
    test_spurious();
    test_random();
    test_exhaust();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
